// File: rtl/sa_operand_feeder.sv
// ---------------------------------------------------------------------------
// sa_operand_feeder
//
// Front end of a 3x3 systolic matrix-multiply array. It accepts two 3x3
// operands P and Q one element per beat over a valid/ready interface. When
// both are buffered, it plays them into the array edge as diagonally skewed,
// zero-padded streams. It then holds the edges at zero while the array
// drains, and pulses done once the array results are final. The array then
// holds Q x P.
//
// Load order (18 beats): beats 0..8 carry P, beats 9..17 carry Q.
//   Q is always row-major. P is row-major by default.
//   Optional feature macro SA_FEEDER_PCOLMAJOR_EN: when it is defined,
//   P arrives column-major instead (row index fastest).
//
// Stream step t (0..6), lane k (1..3):
//   a_k = P[t-(k-1)][k-1] and b_k = Q[k-1][t-(k-1)] when the row/column
//   index lies in 0..2; otherwise the lane is 0.
//
// Ports:
//   clk           clock
//   reset         asynchronous active-low reset
//   abort         synchronous clear, overrides everything else
//   in_valid      in_data carries a beat this cycle
//   in_ready      feeder accepts a beat (registered, high only in LOAD)
//   in_data       operand element
//   a1..a3        column streams into array columns 1..3
//   b1..b3        row streams into array rows 1..3
//   stream_valid  high during the 7 skewed stream steps
//   busy          high during STREAM and DRAIN
//   done          one-cycle pulse after DRAIN
// ---------------------------------------------------------------------------
module sa_operand_feeder #(
    parameter int data_size = 8,
    parameter int grid_size = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_size-1:0] in_data,
    output logic [data_size-1:0] a1,
    output logic [data_size-1:0] a2,
    output logic [data_size-1:0] a3,
    output logic [data_size-1:0] b1,
    output logic [data_size-1:0] b2,
    output logic [data_size-1:0] b3,
    output logic                 stream_valid,
    output logic                 busy,
    output logic                 done
);

    // The port list is hard-wired to three lanes, so only grid_size 3 is legal.
    generate
        if (grid_size != 3) begin : g_bad_grid
            $error("sa_operand_feeder: grid_size must be 3");
        end
    endgenerate

    localparam logic [4:0] LAST_BEAT  = 5'd17;
    localparam logic [4:0] P_BEATS    = 5'd9;
    localparam logic [2:0] LAST_STEP  = 3'd6;
    localparam logic [2:0] LAST_DRAIN = 3'd5;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [4:0]                r_elem;
    logic [2:0]                r_step;
    logic [2:0]                r_drain;
    logic                      r_in_ready;
    logic                      r_stream_valid;
    logic                      r_busy;
    logic                      r_done;
    logic [2:0][data_size-1:0] r_a;
    logic [2:0][data_size-1:0] r_b;
    logic [data_size-1:0]      r_p [0:8];
    logic [data_size-1:0]      r_q [0:8];

    logic                      w_accept;
    logic [3:0]                w_p_addr;
    logic [3:0]                w_q_addr;
    logic [2:0]                w_next_step;
    logic [2:0][data_size-1:0] w_a_nxt;
    logic [2:0][data_size-1:0] w_b_nxt;

`ifdef SA_FEEDER_PCOLMAJOR_EN
    // Maps a column-major P beat index to the row-major buffer slot.
    function automatic logic [3:0] p_colmajor_addr(input logic [3:0] beat);
        logic [3:0] addr;
        case (beat)
            4'd0:    addr = 4'd0;
            4'd1:    addr = 4'd3;
            4'd2:    addr = 4'd6;
            4'd3:    addr = 4'd1;
            4'd4:    addr = 4'd4;
            4'd5:    addr = 4'd7;
            4'd6:    addr = 4'd2;
            4'd7:    addr = 4'd5;
            4'd8:    addr = 4'd8;
            default: addr = 4'd0;
        endcase
        return addr;
    endfunction
`endif

    // Beat acceptance and buffer slot selection.
    always_comb begin
        w_accept = in_valid && r_in_ready && (r_state == ST_LOAD);
`ifdef SA_FEEDER_PCOLMAJOR_EN
        w_p_addr = p_colmajor_addr(r_elem[3:0]);
`else
        w_p_addr = r_elem[3:0];
`endif
        w_q_addr = 4'(r_elem - P_BEATS);
    end

    // Step whose values must be on the outputs after the next edge.
    always_comb begin
        if (r_state == ST_STREAM) begin
            w_next_step = r_step + 3'd1;
        end else begin
            w_next_step = 3'd0;
        end
    end

    // Skewed lane values for w_next_step. A negative row index wraps to
    // >= 6 in three bits, so one "< 3" test covers both range limits.
    always_comb begin
        logic [2:0] v_diff;
        logic [3:0] v_p_idx;
        logic [3:0] v_q_idx;
        w_a_nxt = '0;
        w_b_nxt = '0;
        v_diff  = 3'd0;
        v_p_idx = 4'd0;
        v_q_idx = 4'd0;
        for (int k = 0; k < 3; k++) begin
            v_diff  = w_next_step - 3'(k);
            v_p_idx = ({1'b0, v_diff} * 4'd3) + 4'(k);
            v_q_idx = (4'(k) * 4'd3) + {1'b0, v_diff};
            if (v_diff < 3'd3) begin
                w_a_nxt[k] = r_p[v_p_idx];
                w_b_nxt[k] = r_q[v_q_idx];
            end else begin
                w_a_nxt[k] = '0;
                w_b_nxt[k] = '0;
            end
        end
    end

    // Operand buffers; contents survive reset and abort, and only the load
    // counter decides what is valid.
    always_ff @(posedge clk) begin
        if (w_accept && !abort) begin
            if (r_elem < P_BEATS) begin
                r_p[w_p_addr] <= in_data;
            end else begin
                r_q[w_q_addr] <= in_data;
            end
        end
    end

    // Control FSM with registered stream outputs and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_LOAD;
            r_elem         <= 5'd0;
            r_step         <= 3'd0;
            r_drain        <= 3'd0;
            r_in_ready     <= 1'b0;
            r_stream_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
        end else if (abort) begin
            r_state        <= ST_LOAD;
            r_elem         <= 5'd0;
            r_step         <= 3'd0;
            r_drain        <= 3'd0;
            r_in_ready     <= 1'b1;
            r_stream_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_in_ready <= 1'b1;
                    r_done     <= 1'b0;
                    if (w_accept) begin
                        if (r_elem == LAST_BEAT) begin
                            r_elem         <= 5'd0;
                            r_step         <= 3'd0;
                            r_state        <= ST_STREAM;
                            r_in_ready     <= 1'b0;
                            r_stream_valid <= 1'b1;
                            r_busy         <= 1'b1;
                            r_a            <= w_a_nxt;
                            r_b            <= w_b_nxt;
                        end else begin
                            r_elem <= r_elem + 5'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (r_step == LAST_STEP) begin
                        r_state        <= ST_DRAIN;
                        r_drain        <= 3'd0;
                        r_stream_valid <= 1'b0;
                        r_a            <= '0;
                        r_b            <= '0;
                    end else begin
                        r_step <= w_next_step;
                        r_a    <= w_a_nxt;
                        r_b    <= w_b_nxt;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == LAST_DRAIN) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_LOAD;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state        <= ST_LOAD;
                    r_elem         <= 5'd0;
                    r_in_ready     <= 1'b1;
                    r_stream_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                    r_a            <= '0;
                    r_b            <= '0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign stream_valid = r_stream_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign a1           = r_a[0];
    assign a2           = r_a[1];
    assign a3           = r_a[2];
    assign b1           = r_b[0];
    assign b2           = r_b[1];
    assign b3           = r_b[2];

endmodule

// File: tb/tb_sa_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_sa_operand_feeder
//
// Self-checking bench for sa_operand_feeder. Operands are held as plain 3x3
// matrices. Expected edge streams come from the skew rule applied to those
// matrices. A behavioural 3x3 systolic array fed with the observed streams
// must reproduce Q x P. Honours SA_FEEDER_PCOLMAJOR_EN for the P load order.
// ---------------------------------------------------------------------------
module tb_sa_operand_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] a1, a2, a3, b1, b2, b3;
    logic       stream_valid, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int mp[3][3];
    int mq[3][3];
    int c33;

    sa_operand_feeder #(.data_size(8), .grid_size(3)) dut (
        .clk(clk), .reset(reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
        .stream_valid(stream_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] out_bus();
        return {a1, a2, a3, b1, b2, b3};
    endfunction

    function automatic logic [3:0] out_flags();
        return {stream_valid, busy, done, in_ready};
    endfunction

    task automatic set_model(input bit sequential);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mp[r][c] = sequential ? (r * 3 + c + 1)  : int'($urandom_range(0, 255));
                mq[r][c] = sequential ? (r * 3 + c + 10) : int'($urandom_range(0, 255));
            end
        end
    endtask

    function automatic logic [7:0] beat_value(input int i);
        if (i < 9) begin
`ifdef SA_FEEDER_PCOLMAJOR_EN
            return 8'(mp[i % 3][i / 3]);
`else
            return 8'(mp[i / 3][i % 3]);
`endif
        end
        return 8'(mq[(i - 9) / 3][(i - 9) % 3]);
    endfunction

    // Expected {a1,a2,a3,b1,b2,b3} at stream step t.
    function automatic logic [47:0] exp_streams(input int t);
        logic [7:0] ea[3];
        logic [7:0] eb[3];
        for (int k = 0; k < 3; k++) begin
            ea[k] = 8'd0;
            eb[k] = 8'd0;
            if (t - k >= 0 && t - k < 3) begin
                ea[k] = 8'(mp[t - k][k]);
                eb[k] = 8'(mq[k][t - k]);
            end
        end
        return {ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]};
    endfunction

    // Drives the 18 load beats. When abort_beat matches an accepted beat,
    // abort is raised alongside it and the task returns.
    task automatic load_ops(input bit gaps, input int abort_beat);
        int i = 0;
        int guard = 0;
        while (i < 18) begin
            @(negedge clk);
            abort = 1'b0;
            guard++;
            if (guard > 600) begin
                chk("load_timeout", 64'(i), 64'd18);
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = beat_value(i);
            end
            if (in_valid && in_ready) begin
                if (i == abort_beat) begin
                    abort = 1'b1;
                    return;
                end
                i++;
            end
        end
    endtask

    task automatic post_abort_check(input string tag);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_streams"}, 64'(out_bus()), 64'd0);
        chk({tag, "_flags"}, 64'(out_flags()), 64'b0001);
    endtask

    // Checks the 7 stream, 6 drain, DONE and first LOAD cycles, then runs
    // the observed streams through a behavioural systolic array.
    task automatic check_stream(input bit hold, input int abort_step, output int c22);
        logic [7:0] oa[3][13];
        logic [7:0] ob[3][13];
        logic [3:0] ef;
        int acc;
        int ref_c;
        c22 = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk($sformatf("stream_c%0d", c), 64'(out_bus()),
                (c < 7) ? 64'(exp_streams(c)) : 64'd0);
            if (c < 7)       ef = 4'b1100;
            else if (c < 13) ef = 4'b0100;
            else if (c == 13) ef = 4'b0010;
            else             ef = 4'b0001;
            chk($sformatf("flags_c%0d", c), 64'(out_flags()), 64'(ef));
            if (c < 13) begin
                oa[0][c] = a1; oa[1][c] = a2; oa[2][c] = a3;
                ob[0][c] = b1; ob[1][c] = b2; ob[2][c] = b3;
            end
            in_valid = hold && (c < 13);
            in_data  = 8'($urandom);
            if (c == abort_step) begin
                abort = 1'b1;
                return;
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                ref_c = 0;
                for (int t = 0; t < 13; t++) begin
                    if (t - i >= 0 && t - j >= 0)
                        acc += int'(oa[j][t - i]) * int'(ob[i][t - j]);
                end
                for (int m = 0; m < 3; m++) ref_c += mq[i][m] * mp[m][j];
                chk($sformatf("array_c%0d%0d", i + 1, j + 1), 64'(acc), 64'(ref_c));
                if (i == 2 && j == 2) c22 = acc;
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        // Reset held for three cycles; everything stays low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_streams", 64'(out_bus()), 64'd0);
            chk("reset_flags", 64'(out_flags()), 64'd0);
        end
        reset = 1'b1;
        #1;
        chk("release_ready_low", 64'(out_flags()), 64'd0);
        @(negedge clk);
        chk("release_ready_high", 64'(out_flags()), 64'b0001);

        // Basic stream: P = 1..9, Q = 10..18.
        set_model(1'b1);
        load_ops(1'b0, -1);
        check_stream(1'b0, -1, c33);
        chk("c33_basic", 64'(c33), 64'd312);

        // Same data with input gaps and in_valid held through STREAM/DRAIN.
        load_ops(1'b1, -1);
        check_stream(1'b1, -1, c33);
        chk("c33_backpressure", 64'(c33), 64'd312);

        // Abort at stream step 3, then a fresh load.
        set_model(1'b0);
        load_ops(1'b1, -1);
        check_stream(1'b0, 3, c33);
        post_abort_check("abort_step3");
        set_model(1'b0);
        load_ops(1'b0, -1);
        check_stream(1'b0, -1, c33);

        // Abort colliding with the beat-17 accept: must stay in LOAD.
        set_model(1'b0);
        load_ops(1'b0, 17);
        post_abort_check("abort_collide");
        repeat (3) begin
            @(negedge clk);
            chk("collide_idle_flags", 64'(out_flags()), 64'b0001);
        end
        set_model(1'b0);
        load_ops(1'b1, -1);
        check_stream(1'b0, -1, c33);

        // Abort part-way through a load discards the partial operands.
        set_model(1'b0);
        load_ops(1'b0, 5);
        post_abort_check("abort_partial");
        set_model(1'b0);
        load_ops(1'b0, -1);
        check_stream(1'b1, -1, c33);

        // Reset asserted mid-stream clears outputs without a clock edge.
        set_model(1'b0);
        load_ops(1'b0, -1);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("async_reset_streams", 64'(out_bus()), 64'd0);
        chk("async_reset_flags", 64'(out_flags()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rereset_ready", 64'(out_flags()), 64'b0001);
        set_model(1'b0);
        load_ops(1'b1, -1);
        check_stream(1'b0, -1, c33);

        // Randomised operands, gaps and held valids.
        for (int it = 0; it < 6; it++) begin
            set_model(1'b0);
            load_ops(1'($urandom_range(0, 1)), -1);
            check_stream(1'($urandom_range(0, 1)), -1, c33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
